// File: rtl/cdb_pkg.sv
// ----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common-data-bus arbiter.
//   - default widths and requester count
//   - requester id constants (index into the req_* port vectors)
//   - cdb_entry_t: one completed result (ROB index + value)
//   - rr_wrap: modulo helper for the round-robin scan
// ----------------------------------------------------------------------------
package cdb_pkg;

    localparam int CDB_IDX_W   = 4;
    localparam int CDB_DATA_W  = 16;
    localparam int CDB_NUM_REQ = 4;
    localparam int CDB_SRC_W   = 2;

    localparam int REQ_BRANCH = 0;
    localparam int REQ_LSU    = 1;
    localparam int REQ_FXU1   = 2;
    localparam int REQ_FXU0   = 3;

    typedef struct packed {
        logic [CDB_IDX_W-1:0]  rob_idx;
        logic [CDB_DATA_W-1:0] value;
    } cdb_entry_t;

    // Single-step wrap: valid for 0 <= v < 2*n, which is all the scan needs.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// ----------------------------------------------------------------------------
// cdb_req_fifo
// DEPTH-entry synchronous FIFO holding completed results of one requester.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (empties the queue)
//   flush      empties the queue at the next edge (lower priority than reset)
//   push       write push_data (ignored when full)
//   push_data  entry to enqueue
//   pop        drop the head entry (ignored when empty)
//   head       current head entry, valid whenever empty=0
//   empty      no entries held
//   full       DEPTH entries held
// Pointers wrap modulo DEPTH; the occupancy counter is log2(DEPTH)+1 bits so
// it can represent DEPTH itself. Head is read combinationally because the
// arbiter needs it in the same cycle it decides the grant.
// ----------------------------------------------------------------------------
module cdb_req_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : (p + PTR_W'(1));
    endfunction

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        // Simultaneous push and pop leaves the count untouched.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push && rst_n && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// ----------------------------------------------------------------------------
// cdb_arbiter
// Shares the common data bus among the functional units (0=branch, 1=LSU,
// 2=FXU1, 3=FXU0). Each unit pushes results into its own queue; every cycle
// up to NUM_SLOTS queue heads are granted in round-robin order and loaded
// into the registered CDB slots.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   flush        empty all queues and invalidate the CDB at the next edge
//   req_valid    per-requester result offered
//   req_rob_idx  per-requester ROB index, requester r at [r*IDX_W +: IDX_W]
//   req_value    per-requester value, same packing
//   req_ready    per-requester queue can accept a push
//   cdb_valid    per-slot broadcast valid (one cycle per popped entry)
//   cdb_index    per-slot ROB index
//   cdb_value    per-slot value
//   cdb_src      per-slot requester number
// Build option:
//   CDB_BYPASS_EN  an empty queue competes with its same-cycle incoming result;
//                  if granted that result goes straight onto the CDB and is
//                  never enqueued.
// ----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ   = CDB_NUM_REQ,
    parameter int NUM_SLOTS = 2,
    parameter int IDX_W     = CDB_IDX_W,
    parameter int DATA_W    = CDB_DATA_W,
    parameter int DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*IDX_W-1:0]      req_rob_idx,
    input  logic [NUM_REQ*DATA_W-1:0]     req_value,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_SLOTS-1:0]          cdb_valid,
    output logic [NUM_SLOTS*IDX_W-1:0]    cdb_index,
    output logic [NUM_SLOTS*DATA_W-1:0]   cdb_value,
    output logic [NUM_SLOTS*CDB_SRC_W-1:0] cdb_src
);

    localparam int ENT_W = IDX_W + DATA_W;
    localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ENT_W-1:0]   in_data   [NUM_REQ];
    logic [ENT_W-1:0]   head      [NUM_REQ];
    logic [ENT_W-1:0]   cand_data [NUM_REQ];
    logic [NUM_REQ-1:0] empty, full, accept, cand, grant, push, pop;

    logic [RR_W-1:0] rr_q, rr_d;

    logic [NUM_SLOTS-1:0] slot_vld;
    logic [ENT_W-1:0]     slot_ent [NUM_SLOTS];
    logic [CDB_SRC_W-1:0] slot_src [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]           cdb_valid_q;
    logic [NUM_SLOTS*IDX_W-1:0]     cdb_index_q;
    logic [NUM_SLOTS*DATA_W-1:0]    cdb_value_q;
    logic [NUM_SLOTS*CDB_SRC_W-1:0] cdb_src_q;

    // ------------------------------------------------------------------
    // Per-requester queues and candidate selection
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign in_data[gi]   = {req_rob_idx[gi*IDX_W +: IDX_W], req_value[gi*DATA_W +: DATA_W]};
        // Readiness ignores a same-cycle pop so the path stays short.
        assign req_ready[gi] = ~full[gi] & rst_n & ~flush;
        assign accept[gi]    = req_valid[gi] & req_ready[gi];
`ifdef CDB_BYPASS_EN
        assign cand[gi]      = ~empty[gi] | accept[gi];
        assign cand_data[gi] = empty[gi] ? in_data[gi] : head[gi];
        // A granted bypass result is consumed by the CDB, not stored.
        assign push[gi]      = accept[gi] & ~(grant[gi] & empty[gi]);
`else
        assign cand[gi]      = ~empty[gi];
        assign cand_data[gi] = head[gi];
        assign push[gi]      = accept[gi];
`endif
        assign pop[gi]       = grant[gi] & ~empty[gi];

        cdb_req_fifo #(
            .WIDTH (ENT_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push[gi]),
            .push_data (in_data[gi]),
            .pop       (pop[gi]),
            .head      (head[gi]),
            .empty     (empty[gi]),
            .full      (full[gi])
        );
    end

    // ------------------------------------------------------------------
    // Round-robin grant: scan from rr_q, first NUM_SLOTS candidates win,
    // in scan order onto slot 0, 1, ...
    // ------------------------------------------------------------------
    always_comb begin
        int r;
        int used;
        int last;
        grant    = '0;
        slot_vld = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_ent[s] = '0;
            slot_src[s] = '0;
        end
        used = 0;
        last = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            r = rr_wrap(int'(rr_q) + k, NUM_REQ);
            if (cand[r] && (used < NUM_SLOTS)) begin
                grant[r]       = 1'b1;
                slot_vld[used] = 1'b1;
                slot_ent[used] = cand_data[r];
                slot_src[used] = CDB_SRC_W'(r);
                last           = r;
                used           = used + 1;
            end
        end
        rr_d = (used > 0) ? RR_W'(rr_wrap(last + 1, NUM_REQ)) : rr_q;
    end

    // ------------------------------------------------------------------
    // Registered CDB. Unused slots keep their last index/value/src.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q        <= '0;
            cdb_valid_q <= '0;
            cdb_index_q <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= '0;
        end else if (flush) begin
            // Grants computed this cycle are discarded; pointer is kept.
            cdb_valid_q <= '0;
        end else begin
            rr_q <= rr_d;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                cdb_valid_q[s] <= slot_vld[s];
                if (slot_vld[s]) begin
                    cdb_index_q[s*IDX_W +: IDX_W]         <= slot_ent[s][ENT_W-1 -: IDX_W];
                    cdb_value_q[s*DATA_W +: DATA_W]       <= slot_ent[s][DATA_W-1:0];
                    cdb_src_q[s*CDB_SRC_W +: CDB_SRC_W]   <= slot_src[s];
                end
            end
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_index = cdb_index_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter: a table of directed vectors, a few
// hand-built multi-cycle sequences, then randomized traffic compared against
// a queue-based reference model of the arbiter.
// ----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_REQ   = 4;
    localparam int NUM_SLOTS = 2;
    localparam int DEPTH     = 2;
`ifdef CDB_BYPASS_EN
    localparam bit TAB_OK = 1'b0;
`else
    localparam bit TAB_OK = 1'b1;
`endif

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [3:0]  req_valid;
    logic [15:0] req_rob_idx;
    logic [63:0] req_value;
    logic [3:0]  req_ready;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_index;
    logic [31:0] cdb_value;
    logic [3:0]  cdb_src;

    cdb_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_rob_idx (req_rob_idx),
        .req_value   (req_value),
        .req_ready   (req_ready),
        .cdb_valid   (cdb_valid),
        .cdb_index   (cdb_index),
        .cdb_value   (cdb_value),
        .cdb_src     (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [3:0]  vld;
        logic [15:0] idx;
        logic [63:0] val;
        logic [3:0]  e_rdy;
        logic [1:0]  e_vld;
        logic [7:0]  e_idx;
        logic [31:0] e_val;
        logic [3:0]  e_src;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [3:0] last_ready;

    // ---------------- reference model ----------------
    cdb_entry_t  mq [NUM_REQ][$];
    int          m_rr;
    logic [1:0]  m_vld;
    logic [7:0]  m_idx;
    logic [31:0] m_val;
    logic [3:0]  m_src;

    function automatic logic [3:0] model_ready(input logic rs, input logic fl);
        logic [3:0] rdy;
        for (int r = 0; r < NUM_REQ; r++)
            rdy[r] = rs && !fl && (mq[r].size() < DEPTH);
        return rdy;
    endfunction

    task automatic model_step(input vec_t v);
        logic [3:0] acc;
        cdb_entry_t inc [NUM_REQ];
        cdb_entry_t e;
        bit granted [NUM_REQ];
        bit byp [NUM_REQ];
        int slot, last, r;
        bit has, bp;
        if (!v.rst_n) begin
            for (int q = 0; q < NUM_REQ; q++) mq[q].delete();
            m_rr = 0; m_vld = '0; m_idx = '0; m_val = '0; m_src = '0;
            return;
        end
        acc = v.vld & model_ready(v.rst_n, v.flush);
        if (v.flush) begin
            for (int q = 0; q < NUM_REQ; q++) mq[q].delete();
            m_vld = '0;
            return;
        end
        for (int q = 0; q < NUM_REQ; q++) begin
            inc[q].rob_idx = v.idx[q*4 +: 4];
            inc[q].value   = v.val[q*16 +: 16];
            granted[q] = 0;
            byp[q]     = 0;
        end
        slot = 0; last = 0; m_vld = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            r   = (m_rr + k) % NUM_REQ;
            has = (mq[r].size() > 0);
            bp  = 0;
`ifdef CDB_BYPASS_EN
            bp  = !has && acc[r];
`endif
            if ((has || bp) && slot < NUM_SLOTS) begin
                e = has ? mq[r][0] : inc[r];
                m_vld[slot]          = 1'b1;
                m_idx[slot*4 +: 4]   = e.rob_idx;
                m_val[slot*16 +: 16] = e.value;
                m_src[slot*2 +: 2]   = 2'(r);
                granted[r] = 1;
                byp[r]     = bp;
                last = r;
                slot++;
            end
        end
        if (slot > 0) m_rr = (last + 1) % NUM_REQ;
        for (int q = 0; q < NUM_REQ; q++) begin
            if (granted[q] && !byp[q]) mq[q].delete(0);
            if (acc[q] && !byp[q]) mq[q].push_back(inc[q]);
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cycle(input string tag, input bit use_tab, input vec_t v);
        logic [3:0]  e_rdy;
        logic [1:0]  e_vld;
        logic [7:0]  e_idx;
        logic [31:0] e_val;
        logic [3:0]  e_src;
        rst_n       = v.rst_n;
        flush       = v.flush;
        req_valid   = v.vld;
        req_rob_idx = v.idx;
        req_value   = v.val;
        #1;
        e_rdy = use_tab ? v.e_rdy : model_ready(v.rst_n, v.flush);
        last_ready = req_ready;
        check({tag, "/ready"}, 64'(req_ready), 64'(e_rdy));
        model_step(v);
        @(posedge clk);
        #1;
        cyc++;
        if (use_tab) begin
            e_vld = v.e_vld; e_idx = v.e_idx; e_val = v.e_val; e_src = v.e_src;
        end else begin
            e_vld = m_vld; e_idx = m_idx; e_val = m_val; e_src = m_src;
        end
        check({tag, "/cdb_valid"}, 64'(cdb_valid), 64'(e_vld));
        check({tag, "/cdb_index"}, 64'(cdb_index), 64'(e_idx));
        check({tag, "/cdb_value"}, 64'(cdb_value), 64'(e_val));
        check({tag, "/cdb_src"},   64'(cdb_src),   64'(e_src));
        $display("cyc %0d %s: rst_n=%b flush=%b vld=%b ready=%b -> cdb_valid=%b idx=%h val=%h src=%h",
                 cyc, tag, v.rst_n, v.flush, v.vld, last_ready, cdb_valid, cdb_index, cdb_value, cdb_src);
    endtask

    function automatic vec_t mk(input logic rs, input logic fl, input logic [3:0] vl,
                                input logic [15:0] ix, input logic [63:0] vv);
        vec_t v;
        v = '{rs, fl, vl, ix, vv, 4'h0, 2'b00, 8'h00, 32'h0, 4'h0};
        return v;
    endfunction

    task automatic go(input string tag, input logic rs, input logic fl, input logic [3:0] vl,
                      input logic [15:0] ix, input logic [63:0] vv);
        cycle(tag, 1'b0, mk(rs, fl, vl, ix, vv));
    endtask

    vec_t tab [11];

    initial begin
        // {rst_n, flush, vld, idx, val, exp_ready, exp_valid, exp_idx, exp_val, exp_src}
        tab[0]  = '{1'b0, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b0000, 2'b00, 8'h00, 32'h0000_0000, 4'h0};
        tab[1]  = '{1'b1, 1'b0, 4'b1000, 16'h5000, 64'h1234_0000_0000_0000, 4'b1111, 2'b00, 8'h00, 32'h0000_0000, 4'h0};
        tab[2]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b1111, 2'b01, 8'h05, 32'h0000_1234, 4'h3};
        tab[3]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b1111, 2'b00, 8'h05, 32'h0000_1234, 4'h3};
        tab[4]  = '{1'b1, 1'b0, 4'b1111, 16'h4321, 64'h4444_3333_2222_1111, 4'b1111, 2'b00, 8'h05, 32'h0000_1234, 4'h3};
        tab[5]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b1111, 2'b11, 8'h21, 32'h2222_1111, 4'h4};
        tab[6]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b1111, 2'b11, 8'h43, 32'h4444_3333, 4'hE};
        tab[7]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b1111, 2'b00, 8'h43, 32'h4444_3333, 4'hE};
        tab[8]  = '{1'b1, 1'b0, 4'b1001, 16'h7006, 64'h0707_0000_0000_0606, 4'b1111, 2'b00, 8'h43, 32'h4444_3333, 4'hE};
        tab[9]  = '{1'b1, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b1111, 2'b11, 8'h76, 32'h0707_0606, 4'hC};
        tab[10] = '{1'b1, 1'b0, 4'b0000, 16'h0000, 64'h0, 4'b1111, 2'b00, 8'h76, 32'h0707_0606, 4'hC};

        rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_rob_idx = '0; req_value = '0;
        m_rr = 0; m_vld = '0; m_idx = '0; m_val = '0; m_src = '0;

        // Directed table: reset, single push latency, four-way round robin.
        for (int i = 0; i < 11; i++)
            cycle($sformatf("tab%0d", i), TAB_OK, tab[i]);

        // Full queue refuses a push even while being popped; held data lands later.
        go("t4a", 1, 0, 4'b1101, 16'hA908, 64'hA0A0_9090_0000_8080);
        go("t4b", 1, 0, 4'b0011, 16'h0012, 64'h0000_0000_1010_2020);
        go("t4c", 1, 0, 4'b0010, 16'h0030, 64'h0000_0000_3030_0000);
        go("t4d", 1, 0, 4'b0010, 16'h0040, 64'h0000_0000_4040_0000);
`ifndef CDB_BYPASS_EN
        check("t4_full_ready", 64'(last_ready[1]), 64'd0);
        check("t4_pop_src", 64'(cdb_src[1:0]), 64'd1);
        check("t4_pop_idx", 64'(cdb_index[3:0]), 64'd1);
`endif
        go("t4e", 1, 0, 4'b0010, 16'h0040, 64'h0000_0000_4040_0000);
`ifndef CDB_BYPASS_EN
        check("t4_ready_back", 64'(last_ready[1]), 64'd1);
`endif
        go("t4f", 1, 0, 4'b0000, 16'h0, 64'h0);
`ifndef CDB_BYPASS_EN
        check("t4_held_value", 64'(cdb_value[15:0]), 64'h4040);
`endif
        go("t4g", 1, 0, 4'b0000, 16'h0, 64'h0);

        // Flush with loaded queues and a same-cycle push; pointer survives.
        go("t5h", 1, 0, 4'b1011, 16'h7065, 64'h7070_0000_6060_5050);
        go("t5i", 1, 1, 4'b0001, 16'h0008, 64'h0000_0000_0000_8080);
        check("t5_flush_ready", 64'(last_ready), 64'd0);
        go("t5j", 1, 0, 4'b0000, 16'h0, 64'h0);
        check("t5_empty_valid", 64'(cdb_valid), 64'd0);
        go("t5k", 1, 0, 4'b0000, 16'h0, 64'h0);
        go("t5l", 1, 0, 4'b1010, 16'hB090, 64'hB0B0_0000_9090_0000);
        go("t5m", 1, 0, 4'b0000, 16'h0, 64'h0);
`ifndef CDB_BYPASS_EN
        check("t5_rr_kept_src", 64'(cdb_src), 64'h7);
`endif

        // Reset with busy bus and non-empty queues.
        go("t6n", 1, 0, 4'b1111, 16'h4321, 64'h1111_2222_3333_4444);
        go("t6o", 1, 0, 4'b0000, 16'h0, 64'h0);
`ifndef CDB_BYPASS_EN
        check("t6_busy_valid", 64'(cdb_valid), 64'h3);
`endif
        go("t6p", 0, 0, 4'b1111, 16'h4321, 64'h1111_2222_3333_4444);
        check("t6_rst_ready", 64'(last_ready), 64'd0);
        check("t6_rst_outputs", {cdb_valid, cdb_index, cdb_value, cdb_src}, 64'd0);
        go("t6q", 1, 0, 4'b0000, 16'h0, 64'h0);
        check("t6_release_ready", 64'(last_ready), 64'hF);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            go("rnd",
               ($urandom_range(0, 59) != 0),
               ($urandom_range(0, 29) == 0),
               4'($urandom | $urandom),
               16'($urandom),
               {$urandom, $urandom});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
